traffic_sensor_cond: RTL and testbench

//   Input conditioning stage directly upstream of the traffic-light controller FSM.

---
 rtl/traffic_sensor_cond_if.sv | 20 ++
 rtl/traffic_sensor_cond.sv | 72 +++++++
 tb/tb_traffic_sensor_cond.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/traffic_sensor_cond_if.sv
// rtl/traffic_sensor_cond_if.sv - raw sensor inputs and conditioned flags of the traffic sensor front end
interface traffic_sensor_cond_if;
    logic i_sens_a;
    logic i_sens_b;
    logic i_mode_btn;
    logic o_TA;
    logic o_TB;
    logic o_M;
    logic o_mode_pulse;

    modport master (
        output i_sens_a, i_sens_b, i_mode_btn,
        input  o_TA, o_TB, o_M, o_mode_pulse
    );

    modport slave (
        input  i_sens_a, i_sens_b, i_mode_btn,
        output o_TA, o_TB, o_M, o_mode_pulse
    );
endinterface

// File: rtl/traffic_sensor_cond.sv
// rtl/traffic_sensor_cond.sv - synchronise and debounce car sensors and parade button for the light controller
module traffic_sensor_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    traffic_sensor_cond_if.slave  sens
);

    localparam int            NCH     = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order: 0 = street A, 1 = street B, 2 = mode button.
    logic [NCH-1:0]                  raw;
    logic [NCH-1:0]                  synced;
    logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NCH-1:0]                  stable_q, stable_d;
    logic [NCH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic                            mode_q, mode_d;
    logic                            pulse_q, pulse_d;
    logic                            press;

    assign raw = {sens.i_mode_btn, sens.i_sens_b, sens.i_sens_a};

    always_comb begin
        sync_d   = sync_q;
        synced   = '0;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int ch = 0; ch < NCH; ch++) begin
            sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
            synced[ch] = sync_q[ch][SYNC_STAGES-1];
            // Any sample agreeing with the stable value restarts qualification.
            if (synced[ch] == stable_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_MAX) begin
                stable_d[ch] = synced[ch];
                cnt_d[ch]    = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
        // Press detected from the next stable value so pulse and toggled mode land together.
        press   = stable_d[2] & ~stable_q[2];
        pulse_d = press;
        mode_d  = mode_q ^ press;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            pulse_q  <= pulse_d;
        end
    end

    assign sens.o_TA         = stable_q[0];
    assign sens.o_TB         = stable_q[1];
    assign sens.o_M          = mode_q;
    assign sens.o_mode_pulse = pulse_q;

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb/tb_traffic_sensor_cond.sv - scoreboard bench for traffic_sensor_cond with two sync stages and 4-cycle debounce
module tb_traffic_sensor_cond;

    logic clk = 1'b0;
    logic i_rstn;
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] sb_q[$];

    traffic_sensor_cond_if bus ();

    traffic_sensor_cond #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .i_clk  (clk),
        .i_rstn (i_rstn),
        .sens   (bus.slave)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; the expected {TA,TB,M,pulse} after the
    // next rising edge is queued and is observed at the following falling edge.
    task automatic drive(input logic r, input logic a, input logic b, input logic m,
                         input logic [3:0] e);
        i_rstn         = r;
        bus.i_sens_a   = a;
        bus.i_sens_b   = b;
        bus.i_mode_btn = m;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        i_rstn         = 1'b0;
        bus.i_sens_a   = 1'b0;
        bus.i_sens_b   = 1'b0;
        bus.i_mode_btn = 1'b0;
        @(negedge clk);
        i_rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] got, exp;
        for (int j = 0; j < 11; j++) begin
            drive(j >= 3, 1'b1, 1'b1, j < 3, {j >= 8, j >= 8, 2'b00});
            got = {bus.o_TA, bus.o_TB, bus.o_M, bus.o_mode_pulse};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset step %0d got TA/TB/M/P=%b expected %b", j, got, exp);
            end
        end
    endtask

    task automatic test_sens_a();
        logic [3:0] got, exp;
        apply_reset();
        for (int j = 0; j < 18; j++) begin
            drive(1'b1, j < 10, 1'b0, 1'b0, {(j >= 5 && j < 15), 3'b000});
            got = {bus.o_TA, bus.o_TB, bus.o_M, bus.o_mode_pulse};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sens_a step %0d got TA/TB/M/P=%b expected %b", j, got, exp);
            end
        end
    endtask

    task automatic test_glitch_b();
        logic [3:0] got, exp;
        apply_reset();
        for (int j = 0; j < 25; j++) begin
            drive(1'b1, 1'b0, (j < 3) || (j >= 13 && j < 17), 1'b0,
                  {1'b0, (j >= 18 && j < 22), 2'b00});
            got = {bus.o_TA, bus.o_TB, bus.o_M, bus.o_mode_pulse};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL glitch_b step %0d got TA/TB/M/P=%b expected %b", j, got, exp);
            end
        end
    endtask

    task automatic test_mode();
        logic [3:0] got, exp;
        apply_reset();
        for (int j = 0; j < 37; j++) begin
            drive(1'b1, 1'b0, 1'b0, (j < 10) || (j >= 20 && j < 30),
                  {2'b00, (j >= 5 && j < 25), (j == 5 || j == 25)});
            got = {bus.o_TA, bus.o_TB, bus.o_M, bus.o_mode_pulse};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mode step %0d got TA/TB/M/P=%b expected %b", j, got, exp);
            end
        end
    endtask

    task automatic test_toggle_a();
        logic [3:0] got, exp;
        apply_reset();
        for (int j = 0; j < 17; j++) begin
            drive(1'b1, (j >= 8) || (j % 2 == 0), 1'b0, 1'b0, {j >= 13, 3'b000});
            got = {bus.o_TA, bus.o_TB, bus.o_M, bus.o_mode_pulse};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL toggle_a step %0d got TA/TB/M/P=%b expected %b", j, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, exp;
        apply_reset();
        for (int j = 0; j < 13; j++) begin
            drive(j != 4, 1'b1, 1'b0, 1'b0, {j >= 10, 3'b000});
            got = {bus.o_TA, bus.o_TB, bus.o_M, bus.o_mode_pulse};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_mid step %0d got TA/TB/M/P=%b expected %b", j, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] got, exp;
        apply_reset();
        for (int j = 0; j < 9; j++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, {j >= 5, j >= 5, j >= 5, j == 5});
            got = {bus.o_TA, bus.o_TB, bus.o_M, bus.o_mode_pulse};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL simultaneous step %0d got TA/TB/M/P=%b expected %b", j, got, exp);
            end
        end
    endtask

    initial begin
        i_rstn         = 1'b0;
        bus.i_sens_a   = 1'b1;
        bus.i_sens_b   = 1'b1;
        bus.i_mode_btn = 1'b1;
        @(negedge clk);
        test_reset();
        test_sens_a();
        test_glitch_b();
        test_mode();
        test_toggle_a();
        test_reset_mid();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
